// File: rtl/mem_dma_copy.sv
// rtl/mem_dma_copy.sv - block-copy engine sitting between the host bus and a single-port memory
// When idle, the host bus passes straight through. When started, it copies count words src->dst, one read and one write per word.
module mem_dma_copy #(
   parameter int word_size = 8,
   parameter int len_log_2 = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [len_log_2-1:0] src_addr,
   input  logic [len_log_2-1:0] dst_addr,
   input  logic [len_log_2-1:0] count,
   output logic                 busy,
   output logic                 done,
   input  logic [len_log_2-1:0] host_addr,
   input  logic [word_size-1:0] host_data_in,
   input  logic                 host_we,
   output logic [word_size-1:0] host_data_out,
   output logic [len_log_2-1:0] mem_addr,
   output logic [word_size-1:0] mem_data_in,
   output logic                 mem_we,
   input  logic [word_size-1:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t               state_q, state_d;
   logic [len_log_2-1:0] src_q, src_d;
   logic [len_log_2-1:0] dst_q, dst_d;
   logic [len_log_2-1:0] rem_q, rem_d;
   logic [word_size-1:0] buf_q, buf_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      rem_d       = rem_q;
      buf_d       = buf_q;
      mem_addr    = host_addr;
      mem_data_in = host_data_in;
      mem_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_we = host_we;
            if (start) begin
               src_d   = src_addr;
               dst_d   = dst_addr;
               rem_d   = count;
               state_d = (count == '0) ? DONE : RD;
            end
         end
         RD: begin
            mem_addr = src_q;
            buf_d    = mem_data_out;
            state_d  = WR;
         end
         WR: begin
            mem_addr    = dst_q;
            mem_data_in = buf_q;
            mem_we      = 1'b1;
            // Pointers wrap naturally at the address width.
            src_d       = src_q + 1'b1;
            dst_d       = dst_q + 1'b1;
            rem_d       = rem_q - 1'b1;
            state_d     = (rem_q == len_log_2'(1)) ? DONE : RD;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy          = (state_q == RD) || (state_q == WR);
   assign done          = (state_q == DONE);
   assign host_data_out = mem_data_out;

endmodule

// File: tb/tb_mem_dma_copy.sv
// tb/tb_mem_dma_copy.sv - self-checking bench for mem_dma_copy with a behavioural memory and copy model
module tb_mem_dma_copy;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start;
   logic [15:0] src_addr, dst_addr, count;
   logic        busy, done;
   logic [15:0] host_addr;
   logic [7:0]  host_data_in;
   logic        host_we;
   logic [7:0]  host_data_out;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_in;
   logic        mem_we;
   logic [7:0]  mem_data_out;

   logic        start4;
   logic [3:0]  src4, dst4, count4;
   logic        busy4, done4;
   logic [3:0]  host_addr4;
   logic [7:0]  host_data_in4;
   logic        host_we4;
   logic [7:0]  host_data_out4;
   logic [3:0]  mem_addr4;
   logic [7:0]  mem_data_in4;
   logic        mem_we4;
   logic [7:0]  mem_data_out4;

   mem_dma_copy #(.word_size(8), .len_log_2(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
      .busy(busy), .done(done),
      .host_addr(host_addr), .host_data_in(host_data_in), .host_we(host_we),
      .host_data_out(host_data_out),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
      .mem_data_out(mem_data_out)
   );

   mem_dma_copy #(.word_size(8), .len_log_2(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .src_addr(src4), .dst_addr(dst4), .count(count4),
      .busy(busy4), .done(done4),
      .host_addr(host_addr4), .host_data_in(host_data_in4), .host_we(host_we4),
      .host_data_out(host_data_out4),
      .mem_addr(mem_addr4), .mem_data_in(mem_data_in4), .mem_we(mem_we4),
      .mem_data_out(mem_data_out4)
   );

   logic [7:0] mem  [0:65535];
   logic [7:0] refm [0:65535];
   logic [7:0] mem4 [0:15];

   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data_in;
   always @(posedge clk) if (mem_we4) mem4[mem_addr4] <= mem_data_in4;
   assign mem_data_out  = mem[mem_addr];
   assign mem_data_out4 = mem4[mem_addr4];

   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [15:0] a, input logic [7:0] d);
      host_addr    = a;
      host_data_in = d;
      host_we      = 1'b1;
      tick();
      host_we      = 1'b0;
      refm[a]      = d;
   endtask

   task automatic prefill(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
      for (int i = -1; i <= int'(c) + 1; i++) host_write(16'(int'(s) + i), 8'($urandom));
      for (int i = -1; i <= int'(c) + 1; i++) host_write(16'(int'(d) + i), 8'($urandom));
   endtask

   // Reference: ascending word-by-word copy, so overlapping regions replicate source words.
   task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
      for (int i = 0; i < int'(c); i++) refm[16'(int'(d) + i)] = refm[16'(int'(s) + i)];
   endtask

   task automatic compare_windows(input string tag, input logic [15:0] s, input logic [15:0] d,
                                  input logic [15:0] c);
      int bad;
      logic [15:0] a;
      bad = 0;
      for (int i = -1; i <= int'(c) + 1; i++) begin
         a = 16'(int'(s) + i);
         if (mem[a] !== refm[a]) bad++;
         a = 16'(int'(d) + i);
         if (mem[a] !== refm[a]) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] c, input bit interfere);
      int busy_n, done_at, done_n, we_n;
      src_addr = s;
      dst_addr = d;
      count    = c;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      src_addr = 16'($urandom);
      dst_addr = 16'($urandom);
      count    = 16'($urandom);
      busy_n = 0; done_at = 0; done_n = 0; we_n = 0;
      for (int i = 1; i <= 2 * int'(c) + 4; i++) begin
         if (busy === 1'b1) busy_n++;
         if (mem_we === 1'b1) we_n++;
         if (done === 1'b1) begin
            done_n++;
            if (done_at == 0) done_at = i;
         end
         if (i == 1 && c != 0) check({tag, "_host_view"}, host_data_out, refm[s]);
         if (interfere) begin
            host_we      = busy;
            start        = busy;
            host_addr    = 16'(d + 16'd1);
            host_data_in = 8'hFF;
         end
         tick();
      end
      host_we = 1'b0;
      start   = 1'b0;
      check({tag, "_busy_cycles"}, busy_n, 2 * int'(c));
      check({tag, "_done_at"}, done_at, 2 * int'(c) + 1);
      check({tag, "_done_pulses"}, done_n, 1);
      check({tag, "_writes"}, we_n, int'(c));
      model_copy(s, d, c);
      compare_windows({tag, "_mem"}, s, d, c);
   endtask

   initial begin
      logic [15:0] rs, rd, rc;
      int done_at4;
      reset = 1'b1;
      start = 1'b0; src_addr = '0; dst_addr = '0; count = '0;
      host_addr = 16'h1234; host_data_in = 8'h00; host_we = 1'b0;
      start4 = 1'b0; src4 = '0; dst4 = '0; count4 = '0;
      host_addr4 = '0; host_data_in4 = '0; host_we4 = 1'b0;
      tick();
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_passthrough_addr", mem_addr, 16'h1234);
      reset = 1'b0;
      tick();

      // Test 1: basic 4-word copy
      prefill(16'h0010, 16'h0100, 16'd4);
      host_write(16'h0010, 8'hA1);
      host_write(16'h0011, 8'hA2);
      host_write(16'h0012, 8'hA3);
      host_write(16'h0013, 8'hA4);
      run_copy("t1", 16'h0010, 16'h0100, 16'd4, 1'b0);
      check("t1_dst0", mem[16'h0100], 8'hA1);
      check("t1_dst3", mem[16'h0103], 8'hA4);
      check("t1_src_kept", mem[16'h0012], 8'hA3);

      // Test 2: zero-length copy
      run_copy("t2", 16'h0500, 16'h0600, 16'd0, 1'b0);

      // Test 3: host write and restart attempts during a copy are ignored
      prefill(16'h0010, 16'h0100, 16'd4);
      host_write(16'h0010, 8'hA1);
      host_write(16'h0011, 8'hA2);
      host_write(16'h0012, 8'hA3);
      host_write(16'h0013, 8'hA4);
      run_copy("t3", 16'h0010, 16'h0100, 16'd4, 1'b1);
      check("t3_dropped_write", mem[16'h0101], 8'hA2);
      check("t3_no_restart", busy, 1'b0);

      // Test 5: overlapping forward copy replicates the first word
      prefill(16'h0020, 16'h0021, 16'd3);
      host_write(16'h0020, 8'h55);
      run_copy("t5", 16'h0020, 16'h0021, 16'd3, 1'b0);
      check("t5_w21", mem[16'h0021], 8'h55);
      check("t5_w23", mem[16'h0023], 8'h55);

      // Randomized copies, including address wrap and overlap
      for (int r = 0; r < 6; r++) begin
         rs = 16'($urandom);
         rd = (r % 2 == 0) ? 16'($urandom) : 16'(rs + 16'($urandom_range(0, 6)));
         rc = 16'($urandom_range(0, 10));
         if (r == 2) rs = 16'hFFFC;
         prefill(rs, rd, rc);
         run_copy($sformatf("rand%0d", r), rs, rd, rc, 1'b0);
      end

      // Test 4: narrow address space with source wrap
      for (int a = 0; a < 16; a++) begin
         host_addr4 = 4'(a); host_data_in4 = 8'h00; host_we4 = 1'b1; tick();
      end
      host_addr4 = 4'hE; host_data_in4 = 8'h11; tick();
      host_addr4 = 4'hF; host_data_in4 = 8'h22; tick();
      host_addr4 = 4'h0; host_data_in4 = 8'h33; tick();
      host_we4 = 1'b0;
      src4 = 4'hE; dst4 = 4'h4; count4 = 4'd3; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      done_at4 = 0;
      for (int i = 1; i <= 12; i++) begin
         if (done4 === 1'b1 && done_at4 == 0) done_at4 = i;
         tick();
      end
      check("t4_done_at", done_at4, 7);
      check("t4_w4", mem4[4], 8'h11);
      check("t4_w5", mem4[5], 8'h22);
      check("t4_w6", mem4[6], 8'h33);
      check("t4_w7", mem4[7], 8'h00);

      // Test 6: reset aborts a copy after its second write
      prefill(16'h0010, 16'h0300, 16'd4);
      host_write(16'h0302, 8'h5A);
      src_addr = 16'h0010; dst_addr = 16'h0300; count = 16'd4; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      #1;
      check("t6_busy_async", busy, 1'b0);
      check("t6_done_async", done, 1'b0);
      tick();
      reset = 1'b0;
      check("t6_w0", mem[16'h0300], refm[16'h0010]);
      check("t6_w1", mem[16'h0301], refm[16'h0011]);
      check("t6_w2_untouched", mem[16'h0302], 8'h5A);
      host_write(16'h0400, 8'h3C);
      host_addr = 16'h0400;
      #1;
      check("t6_passthrough_read", host_data_out, 8'h3C);
      check("t6_passthrough_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
